// File: rtl/stream_arbiter_pkg.sv
// Shared constants for the round-robin stream arbiter and its grant selector.
package stream_arbiter_pkg;

  localparam int NUM_SOURCES_DEF = 4;
  localparam int DATA_WIDTH_DEF  = 8;
  localparam int ID_WIDTH_DEF    = $clog2(NUM_SOURCES_DEF);
  localparam int COUNT_WIDTH     = 16;

  // Source-index width, never below one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_grant_select.sv
// Circular first-set search: picks the first request after last_grant, wrapping through last_grant.
module rr_grant_select
  import stream_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES = NUM_SOURCES_DEF,
  parameter int ID_WIDTH    = id_width(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0] request,
  input  logic [ID_WIDTH-1:0]    last_grant,
  output logic [NUM_SOURCES-1:0] grant,
  output logic [ID_WIDTH-1:0]    index,
  output logic                   any
);

  int                  cand;
  logic [ID_WIDTH-1:0] sel;

  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    cand  = 0;
    sel   = '0;
    for (int k = 1; k <= NUM_SOURCES; k++) begin
      cand = (int'(last_grant) + k) % NUM_SOURCES;
      sel  = ID_WIDTH'(cand);
      if (!any && request[sel]) begin
        grant[sel] = 1'b1;
        index      = sel;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_arbiter.sv
// Round-robin merge of NUM_SOURCES valid/ready streams into one registered output stage,
// with a wrapping per-source transfer counter.
module stream_arbiter
  import stream_arbiter_pkg::*;
#(
  parameter  int NUM_SOURCES = NUM_SOURCES_DEF,
  parameter  int DATA_WIDTH  = DATA_WIDTH_DEF,
  localparam int ID_WIDTH    = id_width(NUM_SOURCES)
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [NUM_SOURCES-1:0]                  in_valid,
  output logic [NUM_SOURCES-1:0]                  in_ready,
  input  logic [NUM_SOURCES-1:0][DATA_WIDTH-1:0]  in_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [DATA_WIDTH-1:0]                   out_data,
  output logic [ID_WIDTH-1:0]                     out_id,
  output logic [NUM_SOURCES-1:0][COUNT_WIDTH-1:0] transfer_count
);

  logic                   load;
  logic [ID_WIDTH-1:0]    last_grant;
  logic [NUM_SOURCES-1:0] grant;
  logic [ID_WIDTH-1:0]    grant_idx;
  logic                   grant_any;

  rr_grant_select #(
    .NUM_SOURCES (NUM_SOURCES),
    .ID_WIDTH    (ID_WIDTH)
  ) u_select (
    .request    (in_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .index      (grant_idx),
    .any        (grant_any)
  );

  // The output register can take a new beat when empty or being drained this cycle.
  assign load     = !out_valid || out_ready;
  assign in_ready = grant & {NUM_SOURCES{load && !reset}};

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_id         <= '0;
      last_grant     <= ID_WIDTH'(NUM_SOURCES - 1);
      transfer_count <= '0;
    end else if (load) begin
      if (grant_any) begin
        out_valid                 <= 1'b1;
        out_data                  <= in_data[grant_idx];
        out_id                    <= grant_idx;
        last_grant                <= grant_idx;
        transfer_count[grant_idx] <= transfer_count[grant_idx] + COUNT_WIDTH'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_arbiter.sv
// Bench for stream_arbiter: directed table, corner sequences, random run against a queue-based model.
module tb_stream_arbiter;
  import stream_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic [N-1:0]           in_valid = '0;
  logic [N-1:0]           in_ready;
  logic [N-1:0][DW-1:0]   in_data = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [DW-1:0]          out_data;
  logic [1:0]             out_id;
  logic [N-1:0][15:0]     transfer_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  stream_arbiter #(.NUM_SOURCES(N), .DATA_WIDTH(DW)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_id         (out_id),
    .transfer_count (transfer_count)
  );

  typedef struct {
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_vld;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge: registered outputs settled, inputs may change.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = '1;
    out_ready = 1'b1;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_data", 32'(out_data), 32'h0);
    chk("reset_out_id", 32'(out_id), 32'h0);
    for (int i = 0; i < N; i++) chk("reset_count", 32'(transfer_count[i]), 32'h0);
    reset    = 1'b0;
    in_valid = '0;
    out_ready = 1'b0;
  endtask

  // Reference model: a priority queue of source ids; the granted id moves to the back.
  logic        m_valid;
  logic [7:0]  m_data;
  logic [1:0]  m_id;
  logic [15:0] m_cnt[N];
  int          prio[$];

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_id    = '0;
    prio    = {0, 1, 2, 3};
    for (int i = 0; i < N; i++) m_cnt[i] = '0;
  endtask

  task automatic model_pick(input logic [3:0] iv, input logic ordy, output int g, output logic ld);
    ld = !m_valid || ordy;
    g  = -1;
    if (ld) begin
      foreach (prio[k]) if (g < 0 && iv[prio[k]]) g = prio[k];
    end
  endtask

  task automatic model_commit(input int g, input logic ld, input logic [N-1:0][DW-1:0] d);
    int x;
    if (!ld) return;
    if (g < 0) begin
      m_valid = 1'b0;
      return;
    end
    m_valid = 1'b1;
    m_data  = d[g];
    m_id    = 2'(g);
    m_cnt[g] = m_cnt[g] + 16'd1;
    while (prio[$] != g) begin
      x = prio.pop_front();
      prio.push_back(x);
    end
  endtask

  initial begin
    int          g;
    logic        ld;
    logic [3:0]  exp_rdy;
    logic [7:0]  c[2];
    logic [7:0]  exp_next[4];
    logic [15:0] acc, exp_acc;
    int          delivered[2];
    int          accepted[2];
    int          cycles;
    logic [1:0]  hs;
    logic        ovh;
    logic [7:0]  od;
    logic [1:0]  oid;

    vecs[0] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[1] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[2] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[3] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[4] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[5] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
    vecs[6] = '{4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1};
    vecs[7] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[8] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[9] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};

    tick();
    do_reset();

    // All sources valid: strict rotation 0..3 twice.
    for (int i = 0; i < N; i++) in_data[i] = 8'(8'h40 + i);
    for (int k = 0; k < 8; k++) begin
      in_valid = 4'b1111;
      out_ready = 1'b1;
      #1;
      chk("rot_in_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
      tick();
      chk("rot_out_id", 32'(out_id), 32'(k % 4));
    end
    for (int i = 0; i < N; i++) chk("rot_count", 32'(transfer_count[i]), 32'd2);

    // Directed table.
    do_reset();
    for (int i = 0; i < N; i++) in_data[i] = 8'(8'h30 + i);
    for (int v = 0; v < 10; v++) begin
      in_valid  = vecs[v].iv;
      out_ready = vecs[v].ordy;
      #1;
      chk("tbl_in_ready", 32'(in_ready), 32'(vecs[v].exp_rdy));
      tick();
      chk("tbl_out_valid", 32'(out_valid), 32'(vecs[v].exp_vld));
      chk("tbl_out_id", 32'(out_id), 32'(vecs[v].exp_id));
      chk("tbl_out_data", 32'(out_data), 32'(8'h30 + vecs[v].exp_id));
    end

    // Lone requester served back-to-back.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      in_valid  = 4'b0100;
      in_data[2] = 8'(8'h10 + k);
      out_ready = 1'b1;
      tick();
      chk("lone_out_data", 32'(out_data), 32'(8'h10 + k));
      chk("lone_out_id", 32'(out_id), 32'd2);
    end
    chk("lone_count", 32'(transfer_count[2]), 32'd5);

    // Backpressure hold.
    do_reset();
    in_valid = 4'b0010;
    in_data[1] = 8'hA5;
    out_ready = 1'b1;
    tick();
    chk("bp_first", 32'(out_data), 32'hA5);
    in_valid = 4'b1111;
    for (int i = 0; i < N; i++) in_data[i] = 8'(8'h11 * (i + 1));
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk("bp_out_data", 32'(out_data), 32'hA5);
      chk("bp_out_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(in_ready), 32'(4'b0100));
    tick();
    chk("bp_release_id", 32'(out_id), 32'd2);
    chk("bp_release_data", 32'(out_data), 32'h33);

    // Reset while a beat is pending.
    do_reset();
    in_valid = 4'b0010;
    out_ready = 1'b1;
    tick();
    chk("mid_pre_valid", 32'(out_valid), 32'h1);
    reset = 1'b1;
    in_valid = 4'b1111;
    #1;
    chk("mid_rst_rdy", 32'(in_ready), 32'h0);
    tick();
    chk("mid_out_valid", 32'(out_valid), 32'h0);
    chk("mid_count1", 32'(transfer_count[1]), 32'h0);
    reset = 1'b0;
    #1;
    chk("mid_first_rdy", 32'(in_ready), 32'(4'b0001));
    tick();
    chk("mid_first_id", 32'(out_id), 32'd0);

    // Randomized run against the model.
    do_reset();
    model_reset();
    for (int k = 0; k < 1500; k++) begin
      in_valid  = 4'($urandom);
      for (int i = 0; i < N; i++) in_data[i] = 8'($urandom);
      out_ready = ($urandom % 4) != 0;
      model_pick(in_valid, out_ready, g, ld);
      exp_rdy = (g >= 0) ? 4'(4'b0001 << g) : 4'b0000;
      #1;
      chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
      model_commit(g, ld, in_data);
      tick();
      chk("rnd_out_valid", 32'(out_valid), 32'(m_valid));
      chk("rnd_out_data", 32'(out_data), 32'(m_data));
      chk("rnd_out_id", 32'(out_id), 32'(m_id));
    end
    for (int i = 0; i < N; i++) chk("rnd_count", 32'(transfer_count[i]), 32'(m_cnt[i]));

    // Two 8-bit counter sources feeding a 16-bit accumulator.
    do_reset();
    c[0] = 8'd0; c[1] = 8'd0;
    for (int i = 0; i < 4; i++) exp_next[i] = 8'd0;
    acc = '0;
    delivered[0] = 0; delivered[1] = 0;
    accepted[0] = 0; accepted[1] = 0;
    cycles = 0;
    while ((delivered[0] + delivered[1]) < 1000 && cycles < 6000) begin
      in_valid  = {2'b00, 2'($urandom)};
      in_data[0] = c[0];
      in_data[1] = c[1];
      out_ready = ($urandom % 3) != 0;
      #1;
      hs  = in_valid[1:0] & in_ready[1:0];
      ovh = out_valid && out_ready;
      od  = out_data;
      oid = out_id;
      tick();
      cycles++;
      for (int i = 0; i < 2; i++) if (hs[i]) begin
        c[i] = c[i] + 8'd1;
        accepted[i]++;
      end
      if (ovh) begin
        chk("acc_seq", {22'd0, oid, od}, {22'd0, oid, exp_next[oid]});
        exp_next[oid] = exp_next[oid] + 8'd1;
        acc = acc + 16'(od);
        if (oid < 2) delivered[oid]++;
      end
    end
    chk("acc_budget", 32'(cycles < 6000), 32'd1);
    exp_acc = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < delivered[i]; j++) exp_acc = exp_acc + 16'(j % 256);
    chk("acc_sum", 32'(acc), 32'(exp_acc));
    chk("acc_count0", 32'(transfer_count[0]), 32'(accepted[0]));
    chk("acc_count1", 32'(transfer_count[1]), 32'(accepted[1]));

    // Counter wrap after 65536 transfers from source 0.
    do_reset();
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    for (int k = 0; k < 65535; k++) tick();
    chk("wrap_ffff", 32'(transfer_count[0]), 32'hFFFF);
    tick();
    chk("wrap_zero", 32'(transfer_count[0]), 32'h0);
    for (int i = 1; i < N; i++) chk("wrap_others", 32'(transfer_count[i]), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
